// File: rtl/dram_responder.sv
`default_nettype none
// =============================================================================
// dram_responder: memory-side responder with in-order fixed-latency read queue.
// Revision 1.0
// =============================================================================
module dram_responder #(
  parameter int GBW       = 32,
  parameter int DBW       = 32,
  parameter int CSIZE     = 32,
  parameter int MEM_LINES = 256,
  parameter int RD_LAT    = 4,
  parameter int RQ_DEPTH  = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_dramra_rdy,
  output logic                             o_dramra_ack,
  input  logic [GBW-1:0]                   i_dramra,
  output logic                             o_dramrd_rdy,
  input  logic                             i_dramrd_ack,
  output logic [CSIZE*DBW-1:0]             o_dramrd,
  input  logic                             i_dramw_rdy,
  output logic                             o_dramw_ack,
  input  logic [GBW-1:0]                   i_dramwa,
  input  logic [CSIZE*DBW-1:0]             i_dramwd,
  input  logic [CSIZE-1:0]                 i_dramw_mask,
  output logic [$clog2(RQ_DEPTH+1)-1:0]    o_rq_count
);

  localparam int OFFW  = $clog2(CSIZE);
  localparam int LW    = $clog2(MEM_LINES);
  localparam int LINEW = CSIZE * DBW;
  localparam int CW    = $clog2(RQ_DEPTH + 1);
  localparam int PW    = $clog2(RQ_DEPTH);
  localparam int TW    = $clog2(RD_LAT + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(RQ_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(RQ_DEPTH - 1);
  // The acceptance cycle itself counts as the first latency cycle.
  localparam logic [TW-1:0] LOAD_C  = TW'(RD_LAT - 1);

  logic [LINEW-1:0] mem_q     [MEM_LINES];
  logic [LINEW-1:0] rq_line_q [RQ_DEPTH];
  logic [TW-1:0]    rq_cnt_q  [RQ_DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [LW-1:0] w_ra_line;
  logic [LW-1:0] w_wa_line;
  logic          w_ra_fire;
  logic          w_rd_fire;
  logic          w_w_fire;
  logic          w_head_mature;
  logic          unused_addr;

  assign w_ra_line   = i_dramra[OFFW +: LW];
  assign w_wa_line   = i_dramwa[OFFW +: LW];
  assign unused_addr = ^{i_dramra, i_dramwa};

  assign o_dramra_ack = !i_rst && i_dramra_rdy && (count_q < DEPTH_C);
  assign o_dramw_ack  = !i_rst && i_dramw_rdy;

  assign w_head_mature = (count_q != '0) && (rq_cnt_q[head_q] == '0);
  assign o_dramrd_rdy  = w_head_mature;
  assign o_dramrd      = w_head_mature ? rq_line_q[head_q] : '0;
  assign o_rq_count    = count_q;

  assign w_ra_fire = o_dramra_ack;
  assign w_rd_fire = o_dramrd_rdy && i_dramrd_ack;
  assign w_w_fire  = o_dramw_ack;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int l = 0; l < MEM_LINES; l++) begin
        mem_q[l] <= '0;
      end
    end else if (w_w_fire) begin
      for (int i = 0; i < CSIZE; i++) begin
        if (i_dramw_mask[i]) begin
          mem_q[w_wa_line][i*DBW +: DBW] <= i_dramwd[i*DBW +: DBW];
        end
      end
    end
  end

  // Snapshot uses the pre-edge memory value, so a same-cycle write is not seen.
  always_ff @(posedge i_clk) begin
    for (int e = 0; e < RQ_DEPTH; e++) begin
      if (rq_cnt_q[e] != '0) begin
        rq_cnt_q[e] <= rq_cnt_q[e] - TW'(1);
      end
    end
    if (w_ra_fire) begin
      rq_line_q[tail_q] <= mem_q[w_ra_line];
      rq_cnt_q[tail_q]  <= LOAD_C;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (w_ra_fire) begin
      tail_d = (tail_q == LAST_C) ? '0 : tail_q + PW'(1);
    end
    if (w_rd_fire) begin
      head_d = (head_q == LAST_C) ? '0 : head_q + PW'(1);
    end
    case ({w_ra_fire, w_rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dram_responder.sv
`default_nettype none
// =============================================================================
// tb_dram_responder: directed self-checking bench for dram_responder.
// Revision 1.0
// =============================================================================
module tb_dram_responder;

  localparam int GBW       = 32;
  localparam int DBW       = 32;
  localparam int CSIZE     = 32;
  localparam int MEM_LINES = 256;
  localparam int RD_LAT    = 4;
  localparam int RQ_DEPTH  = 4;
  localparam int LINEW     = CSIZE * DBW;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  ra_rdy = 1'b0;
  logic                  ra_ack;
  logic [GBW-1:0]        ra = '0;
  logic                  rd_rdy;
  logic                  rd_ack = 1'b0;
  logic [LINEW-1:0]      rd;
  logic                  w_rdy = 1'b0;
  logic                  w_ack;
  logic [GBW-1:0]        wa = '0;
  logic [LINEW-1:0]      wd = '0;
  logic [CSIZE-1:0]      wmask = '0;
  logic [2:0]            rq_count;

  int n_pass  = 0;
  int n_total = 0;

  dram_responder #(
    .GBW(GBW), .DBW(DBW), .CSIZE(CSIZE), .MEM_LINES(MEM_LINES),
    .RD_LAT(RD_LAT), .RQ_DEPTH(RQ_DEPTH)
  ) u_dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_dramra_rdy(ra_rdy),
    .o_dramra_ack(ra_ack),
    .i_dramra(ra),
    .o_dramrd_rdy(rd_rdy),
    .i_dramrd_ack(rd_ack),
    .o_dramrd(rd),
    .i_dramw_rdy(w_rdy),
    .o_dramw_ack(w_ack),
    .i_dramwa(wa),
    .i_dramwd(wd),
    .i_dramw_mask(wmask),
    .o_rq_count(rq_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] word(input int i);
    return rd[i*DBW +: DBW];
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LINEW-1:0] line;

    // Reset state, with rdy inputs high to confirm acks are blocked.
    #1;
    rst = 1'b1;
    ra_rdy = 1'b1;
    w_rdy = 1'b1;
    #1;
    check("rst_count", 32'(rq_count), 0);
    check("rst_rd_rdy", 32'(rd_rdy), 0);
    check("rst_rd_word0", word(0), 0);
    check("rst_ra_ack", 32'(ra_ack), 0);
    check("rst_w_ack", 32'(w_ack), 0);
    tick();
    tick();
    ra_rdy = 1'b0;
    w_rdy = 1'b0;
    rst = 1'b0;

    // Full-line write to 0x40, then read it back with RD_LAT latency.
    line = '0;
    for (int i = 0; i < CSIZE; i++) line[i*DBW +: DBW] = 32'hA5A5_0000 + 32'(i);
    wa = 32'h40; wd = line; wmask = '1; w_rdy = 1'b1;
    settle();
    check("w_ack", 32'(w_ack), 1);
    tick();
    w_rdy = 1'b0; wmask = '0;
    ra = 32'h40; ra_rdy = 1'b1;
    settle();
    check("ra_ack_empty", 32'(ra_ack), 1);
    tick();
    ra_rdy = 1'b0;
    for (int k = 1; k < RD_LAT; k++) begin
      settle();
      check("rd_rdy_early", 32'(rd_rdy), 0);
      tick();
    end
    settle();
    check("rd_rdy_at_lat", 32'(rd_rdy), 1);
    for (int i = 0; i < CSIZE; i++) check("line40_word", word(i), 32'hA5A5_0000 + 32'(i));
    tick();
    check("rd_rdy_hold", 32'(rd_rdy), 1);
    check("rd_hold_word5", word(5), 32'hA5A5_0005);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    settle();
    check("rd_rdy_after_pop", 32'(rd_rdy), 0);
    check("rd_zero_idle", word(0), 0);
    check("count_after_pop", 32'(rq_count), 0);

    // Tag lines 20..24 so response order is visible.
    for (int k = 0; k < 5; k++) begin
      wa = 32'((20 + k) << 5);
      wd = '0; wd[DBW-1:0] = 32'h100 + 32'(k);
      wmask = 32'h1; w_rdy = 1'b1;
      tick();
    end
    w_rdy = 1'b0; wmask = '0;

    // Fill the queue with four back-to-back reads.
    ra_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ra = 32'((20 + k) << 5);
      settle();
      check("ra_ack_fill", 32'(ra_ack), 1);
      tick();
    end
    ra = 32'(24 << 5);
    settle();
    check("ra_ack_full", 32'(ra_ack), 0);
    check("count_full", 32'(rq_count), 4);
    check("head_mature_full", 32'(rd_rdy), 1);
    check("head_word_full", word(0), 32'h100);
    rd_ack = 1'b1;
    settle();
    check("ra_ack_full_pop", 32'(ra_ack), 0);
    tick();
    rd_ack = 1'b0;
    settle();
    check("count_after_full_pop", 32'(rq_count), 3);
    check("ra_ack_after_pop", 32'(ra_ack), 1);
    tick();
    ra_rdy = 1'b0;
    settle();
    check("count_refill", 32'(rq_count), 4);
    rd_ack = 1'b1;
    for (int k = 1; k < 5; k++) begin
      settle();
      check("drain_rdy", 32'(rd_rdy), 1);
      check("drain_order", word(0), 32'h100 + 32'(k));
      tick();
    end
    rd_ack = 1'b0;
    settle();
    check("drain_count", 32'(rq_count), 0);
    check("drain_rdy_end", 32'(rd_rdy), 0);

    // Single-word masked write, then a zero-mask write that must not land.
    pulse_reset();
    wa = 32'h60; wd = '1; wmask = 32'h1; w_rdy = 1'b1;
    tick();
    wd = {CSIZE{32'h5A5A_5A5A}}; wmask = '0;
    settle();
    check("w_ack_zero_mask", 32'(w_ack), 1);
    tick();
    w_rdy = 1'b0;
    ra = 32'h60; ra_rdy = 1'b1;
    tick();
    ra_rdy = 1'b0;
    repeat (RD_LAT - 1) tick();
    settle();
    check("mask_rdy", 32'(rd_rdy), 1);
    for (int i = 0; i < CSIZE; i++) check("mask_word", word(i), (i == 0) ? 32'hFFFF_FFFF : 32'h0);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;

    // Same-cycle read and write of line 7, then a follow-up read.
    wa = 32'hE0; wd = '0; wd[DBW-1:0] = 32'h1234; wmask = 32'h1; w_rdy = 1'b1;
    ra = 32'hE0; ra_rdy = 1'b1;
    tick();
    w_rdy = 1'b0; wmask = '0;
    tick();
    ra_rdy = 1'b0;
    tick();
    tick();
    settle();
    check("rw_same_rdy", 32'(rd_rdy), 1);
    check("rw_same_old", word(0), 0);
    rd_ack = 1'b1;
    tick();
    check("rw_next_rdy", 32'(rd_rdy), 1);
    check("rw_next_new", word(0), 32'h1234);
    tick();
    rd_ack = 1'b0;
    settle();
    check("rw_count", 32'(rq_count), 0);

    // Reset pulse discards pending reads and clears memory.
    ra = 32'hE0; ra_rdy = 1'b1;
    tick();
    tick();
    ra_rdy = 1'b0;
    settle();
    check("pending_count", 32'(rq_count), 2);
    rst = 1'b1;
    settle();
    check("async_rst_count", 32'(rq_count), 0);
    check("async_rst_rdy", 32'(rd_rdy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      settle();
      check("post_rst_rdy", 32'(rd_rdy), 0);
      tick();
    end
    check("post_rst_count", 32'(rq_count), 0);
    ra = 32'hE0; ra_rdy = 1'b1;
    tick();
    ra_rdy = 1'b0;
    repeat (RD_LAT - 1) tick();
    settle();
    check("post_rst_read_rdy", 32'(rd_rdy), 1);
    check("post_rst_mem_zero", word(0), 0);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dram_responder.md
DRAM_RESPONDER -- requirements
Module: DramResponder

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- GBW, 32, word address width.
- DBW, 32, data word width.
- CSIZE, 32, words per line; power of two.
- MEM_LINES, 256, lines of backing store; power of two.
- RD_LAT, 4, read latency in cycles; at least 1.
- RQ_DEPTH, 4, read queue entries; at least 2.

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_dramra_rdy  in  1  read address valid.
- o_dramra_ack  out  1  read address accepted.
- i_dramra  in  GBW  read word address.
- o_dramrd_rdy  out  1  read data valid.
- i_dramrd_ack  in  1  read data consumed.
- o_dramrd  out  CSIZE x DBW  read line.
- i_dramw_rdy  in  1  write valid.
- o_dramw_ack  out  1  write accepted.
- i_dramwa  in  GBW  write word address.
- i_dramwd  in  CSIZE x DBW  write line.
- i_dramw_mask  in  CSIZE  per-word write enable.
- o_rq_count  out  clog2(RQ_DEPTH+1)  occupied read-queue entries.

REQ-003 The block SHALL be the memory-side responder for an initiator's dramra/dramrd/dramw rdy/ack channels, with one clock i_clk and asynchronous active-high reset i_rst.

Function
REQ-004 Each channel SHALL transfer on any cycle where rdy and ack are both 1.
- Ack SHALL never be 1 while the matching rdy is 0.
- A sender holds its payload stable until acked.
REQ-005 Line index SHALL be addr[log2(CSIZE) +: log2(MEM_LINES)].
- Word-offset bits and higher bits SHALL be ignored; higher bits alias.
REQ-006 o_dramra_ack SHALL equal i_dramra_rdy AND (o_rq_count < RQ_DEPTH), combinationally.
- A dequeue in the same cycle SHALL NOT relieve a full queue.
REQ-007 On read acceptance, the addressed line SHALL be snapshotted into the queue tail together with a countdown of RD_LAT.
- The snapshot reflects memory state before any write accepted in the same cycle.
REQ-008 Each entry's countdown SHALL decrement each cycle, saturating at 0.
REQ-009 An entry accepted in cycle t SHALL have o_dramrd_rdy first assertable in cycle t+RD_LAT, provided it is at the head.
REQ-010 o_dramrd_rdy SHALL be 1 exactly when the queue is non-empty and the head countdown is 0.
- o_dramrd SHALL present the head snapshot.
- Both SHALL stay stable until i_dramrd_ack.
REQ-011 Responses SHALL be returned strictly in acceptance order.
REQ-012 On a cycle with rdy and ack both 1 on dramrd, the head SHALL be popped; the next entry may present on the following cycle.
- Back-to-back mature entries SHALL therefore sustain one line per cycle.
REQ-013 Simultaneous enqueue and dequeue on a non-full queue SHALL leave o_rq_count unchanged.
- Pointers SHALL wrap modulo RQ_DEPTH.
REQ-014 o_dramw_ack SHALL equal i_dramw_rdy, so writes have zero wait.
REQ-015 On a write transfer, word i of the line SHALL be updated at the clock edge iff i_dramw_mask[i]=1.
- An all-zero mask SHALL be acked with no effect.
REQ-016 A read accepted in the cycle after a write to the same line SHALL observe the written data.
REQ-017 Read and write transfers in the same cycle SHALL be independent; the read sees the old data.
REQ-018 o_dramrd SHALL be all-zero whenever o_dramrd_rdy=0.

Reset
REQ-019 While i_rst=1 (asynchronous assertion), the following SHALL hold:
- the queue is emptied;
- o_rq_count=0, o_dramrd_rdy=0, o_dramrd=0;
- all backing-store words are 0.
REQ-020 Reset asserted mid-operation SHALL discard all pending reads; no response SHALL be issued for them after release.
REQ-021 o_dramra_ack and o_dramw_ack SHALL be 0 while i_rst=1.

Verification
REQ-022 Write addr 0x40, all words 0xA5A5_0000+i, mask all-ones; read addr 0x40 at t.
- Required: o_dramrd_rdy first high at t+4; word i = 0xA5A5_0000+i.
REQ-023 Five reads issued back-to-back with i_dramrd_ack held 0.
- Required: four acked; o_rq_count=4; fifth rdy not acked until the first pop, then acked the cycle after.
REQ-024 Mask 0x0000_0001 write of 0xFFFF_FFFF to line 3 after reset, then read line 3.
- Required: word 0 = 0xFFFF_FFFF; words 1..31 = 0.
REQ-025 Read and write of line 7 in the same cycle, with old value 0 and new value 0x1234.
- Required: read returns 0; a second read the next cycle returns 0x1234.
REQ-026 Two reads queued, i_rst pulsed for 1 cycle before maturity.
- Required: o_dramrd_rdy stays 0 thereafter; o_rq_count=0; memory reads 0.
REQ-027 Queue full with one mature head, i_dramrd_ack=1 and i_dramra_rdy=1 in the same cycle.
- Required: pop occurs, o_dramra_ack=0 that cycle, o_rq_count 4->3, then acked next cycle.
